// File: rtl/shared_mem_arbiter.sv
// ============================================================================
// Module      : shared_mem_arbiter
// Description : Round-robin arbiter sharing one synchronous data memory among
//               NUM_CORES cores, one access in flight, all outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shared_mem_arbiter #(
  parameter int NUM_CORES  = 2,
  parameter int SEL_WIDTH  = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CORES-1:0]            req_valid,
  input  logic [NUM_CORES-1:0]            req_write,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_CORES-1:0]            req_ready,
  output logic [NUM_CORES-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic                            mem_read_en,
  output logic                            mem_write_en,
  output logic [DATA_WIDTH-1:0]           mem_write_val,
  input  logic [DATA_WIDTH-1:0]           mem_read_val,
  output logic                            busy,
  output logic [SEL_WIDTH-1:0]            last_grant
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  localparam logic [SEL_WIDTH-1:0] c_LAST_RESET = SEL_WIDTH'(NUM_CORES - 1);

  state_t                  r_state;
  logic [NUM_CORES-1:0]    r_grant;
  logic                    r_write;
  logic [NUM_CORES-1:0]    r_req_ready;
  logic [NUM_CORES-1:0]    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_write_val;
  logic                    r_mem_read_en;
  logic                    r_mem_write_en;
  logic                    r_busy;
  logic [SEL_WIDTH-1:0]    r_last_grant;

  logic                    w_found;
  logic [SEL_WIDTH-1:0]    w_idx;
  logic [SEL_WIDTH-1:0]    w_sel;
  logic                    w_write;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [NUM_CORES-1:0]    w_onehot;

  // Circular search starting one past the last granted core.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_sel   = '0;
    w_write = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      w_idx = SEL_WIDTH'((int'(r_last_grant) + i) % NUM_CORES);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
        w_write = req_write[w_idx];
        w_addr  = req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata = req_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    w_onehot = NUM_CORES'(1) << w_sel;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_grant         <= '0;
      r_write         <= 1'b0;
      r_req_ready     <= '0;
      r_rsp_valid     <= '0;
      r_rsp_rdata     <= '0;
      r_mem_addr      <= '0;
      r_mem_write_val <= '0;
      r_mem_read_en   <= 1'b0;
      r_mem_write_en  <= 1'b0;
      r_busy          <= 1'b0;
      r_last_grant    <= c_LAST_RESET;
    end else begin
      // Strobes and pulses are single-cycle unless re-asserted below.
      r_req_ready    <= '0;
      r_rsp_valid    <= '0;
      r_mem_read_en  <= 1'b0;
      r_mem_write_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state         <= S_ACCESS;
            r_grant         <= w_onehot;
            r_last_grant    <= w_sel;
            r_write         <= w_write;
            r_mem_addr      <= w_addr;
            r_mem_write_val <= w_wdata;
            r_req_ready     <= w_onehot;
            r_mem_write_en  <= w_write;
            r_mem_read_en   <= !w_write;
            r_busy          <= 1'b1;
          end
        end
        S_ACCESS: begin
          if (r_write) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_rsp_valid <= r_grant;
          r_rsp_rdata <= mem_read_val;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign mem_addr      = r_mem_addr;
  assign mem_write_val = r_mem_write_val;
  assign mem_read_en   = r_mem_read_en;
  assign mem_write_en  = r_mem_write_en;
  assign busy          = r_busy;
  assign last_grant    = r_last_grant;

endmodule

`default_nettype wire

// File: doc/shared_mem_arbiter.md
# shared_mem_arbiter

Round-robin arbiter that lets `NUM_CORES` processor cores share one synchronous data memory. It replaces the per-core private data memory in the multi-core processor top level. Each core port uses a valid/ready request handshake and receives a one-cycle response strobe. All outputs are registered, and one memory access is in flight at a time.

## Interface
Parameters:
- `NUM_CORES`, default 2: number of requesting cores; legal range 2..16.
- `SEL_WIDTH`, default 1: width of the core index; must be ≥ clog2(`NUM_CORES`).
- `ADDR_WIDTH`, default 32: memory address width.
- `DATA_WIDTH`, default 32: memory data width.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  `NUM_CORES`  bit i: core i requests an access.
- `req_write`  in  `NUM_CORES`  bit i: 1 = write, 0 = read.
- `req_addr`  in  `NUM_CORES*ADDR_WIDTH`  core i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata`  in  `NUM_CORES*DATA_WIDTH`  core i at [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  `NUM_CORES`  one-hot, one-cycle accept pulse.
- `rsp_valid`  out  `NUM_CORES`  one-hot, one-cycle read-data-valid pulse.
- `rsp_rdata`  out  `DATA_WIDTH`  read data; valid only while `rsp_valid` is nonzero.
- `mem_addr`  out  `ADDR_WIDTH`  memory address.
- `mem_read_en`  out  1  memory read strobe.
- `mem_write_en`  out  1  memory write strobe.
- `mem_write_val`  out  `DATA_WIDTH`  memory write data.
- `mem_read_val`  in  `DATA_WIDTH`  memory read data; valid in the cycle after `mem_read_en`.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `last_grant`  out  `SEL_WIDTH`  index of the most recently granted core.

## Operation
- FSM states: IDLE, ACCESS, WAIT.
- IDLE:
  - If any `req_valid` bit is set, grant the first requesting core in circular order, starting at (`last_grant`+1) mod `NUM_CORES`.
  - Latch that core's addr, wdata and write flag into the memory-side registers.
  - Update `last_grant` and go to ACCESS.
  - If no bit is set, stay in IDLE.
- ACCESS (exactly one cycle):
  - `req_ready[g]`=1.
  - `mem_write_en`=write flag, `mem_read_en`=!write flag.
  - `mem_addr`/`mem_write_val` hold the latched values.
  - Next state: IDLE if the access is a write, WAIT if it is a read.
- WAIT (exactly one cycle):
  - All strobes low.
  - Capture `mem_read_val` into `rsp_rdata` at the end of the cycle.
  - Next state: IDLE, with `rsp_valid[g]`=1 during that IDLE cycle.
- Core obligations:
  - Hold `req_valid` and the payload stable until `req_ready` is seen.
  - Deassert `req_valid` (or present the next request) after the `req_ready` cycle.
  - The arbiter never samples request inputs outside IDLE.
- Requests from non-granted cores stay pending; they are never dropped or reordered within a core.
- `mem_addr`/`mem_write_val` hold their last value outside ACCESS; only the strobes gate memory activity.
- Reset values (the state applied on any edge where `reset`=0):
  - State IDLE.
  - `req_ready`, `rsp_valid`, `mem_read_en`, `mem_write_en`, `busy` all 0.
  - `mem_addr`, `mem_write_val`, `rsp_rdata` 0.
  - `last_grant`=`NUM_CORES`-1, so core 0 wins first.

## Timing
- E0 is the edge that samples `req_valid` in IDLE.
- Write: `req_ready` and `mem_write_en` are high in the cycle after E0. The next arbitration is sampled 2 edges after E0, giving peak write throughput of 1 per 2 cycles.
- Read:
  - `mem_read_en` is high in cycle E0+1.
  - WAIT occupies E1..E2.
  - `rsp_valid`/`rsp_rdata` are valid in cycle E2..E3, a latency of 3 cycles from E0.
  - A new grant may be decided at E3, in the same cycle `rsp_valid` is high; the response and the new grant are independent.
- Simultaneous requests: exactly one grant per arbitration. With all `NUM_CORES` cores continuously requesting, every core is granted once every `NUM_CORES` grants.
- Reset mid-operation (ACCESS or WAIT): the transaction is aborted and no `rsp_valid` is issued. The core re-requests after reset.
- `busy`=0 exactly when in IDLE.

## Test plan
- Single read: core 0 reads addr 0x10; memory returns 0xCAFEF00D. Expect `req_ready`=2'b01 at E0+1, `mem_read_en` for 1 cycle, then `rsp_valid`=2'b01 with `rsp_rdata`=0xCAFEF00D at E0+3.
- Contention (`NUM_CORES`=2): both cores hold read requests from the cycle after reset. Expect grant order 0,1,0,1 and `last_grant` toggling; no core starves.
- Write then read: core 1 writes 0x12345678 to addr 0x20, then reads addr 0x20 back. Expect `mem_write_en` for 1 cycle, `rsp_rdata`=0x12345678, and `rsp_valid`=2'b10.
- Reset in WAIT: drive `reset`=0 for one edge during WAIT. Expect state IDLE, `busy`=0, all strobes 0, no `rsp_valid` pulse, and `last_grant`=`NUM_CORES`-1.
- `NUM_CORES`=4, `SEL_WIDTH`=2: cores 0, 1 and 3 request continuously and core 2 is idle. Expect grant sequence 0,1,3,0,1,3 and `req_ready` never 4'b0100.
- Idle bus: `req_valid`=0 for 20 cycles. Expect `busy`=0, all strobes 0, and `last_grant` unchanged.
